// File: rtl/sobel_pkg.sv
// Shared types, defaults and helpers for the Sobel frame controller.
// Bus widths are fixed; counter widths inside the design follow the image size.
package sobel_pkg;

    localparam int IMG_W_DEF = 128;
    localparam int IMG_H_DEF = 128;
    localparam int PIX_W     = 8;
    localparam int ADDR_W    = 14;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } ctrl_state_t;

    // A 3x3 kernel yields no result on the one-pixel border.
    function automatic int out_cnt(input int w, input int h);
        return (w - 2) * (h - 2);
    endfunction

endpackage

// File: rtl/sobel_frame_ctrl_if.sv
// Control, source-read, filter and result-write signals of the Sobel frame controller.
// The master side is the controller; the slave side is the surrounding system.
interface sobel_frame_ctrl_if;
    import sobel_pkg::*;

    logic              start;
    logic              abort;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;
    logic              filt_ready;
    logic [PIX_W-1:0]  pixel_data;
    logic              pix_valid;
    logic [PIX_W-1:0]  edge_pixel;
    logic              edge_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              busy;
    logic              done;
    logic              timeout;

    modport master (
        input  start, abort, rd_data, filt_ready, edge_pixel, edge_valid,
        output rd_en, rd_addr, pixel_data, pix_valid,
               wr_en, wr_addr, wr_data, busy, done, timeout
    );

    modport slave (
        output start, abort, rd_data, filt_ready, edge_pixel, edge_valid,
        input  rd_en, rd_addr, pixel_data, pix_valid,
               wr_en, wr_addr, wr_data, busy, done, timeout
    );

endinterface

// File: rtl/sobel_frame_addr_gen.sv
// Source read address generator: raster counter gated by filter backpressure,
// plus alignment of the pixel-valid flag with the one-cycle read latency.
module sobel_frame_addr_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic              filt_ready,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              last_read,
    output logic              pix_valid,
    output logic [PIX_W-1:0]  pixel_data
);

    localparam int               NPIX      = IMG_W * IMG_H;
    localparam int               CNT_W     = $clog2(NPIX);
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(NPIX - 1);

    logic [CNT_W-1:0] rd_cnt;
    logic             valid_q;

    assign rd_en      = enable && filt_ready;
    assign rd_addr    = ADDR_W'(rd_cnt);
    assign last_read  = rd_en && (rd_cnt == LAST_ADDR);
    assign pix_valid  = valid_q;
    assign pixel_data = valid_q ? rd_data : '0;

    // The counter parks on the last address so it never wraps inside a frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_cnt  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_en;
            if (clear) begin
                rd_cnt <= '0;
            end else if (rd_en && !last_read) begin
                rd_cnt <= rd_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame controller that streams a source image into a Sobel filter and writes
// the filter results back, with drain timeout, abort and status reporting.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W     = IMG_W_DEF,
    parameter int IMG_H     = IMG_H_DEF,
    parameter int DRAIN_MAX = 1024
) (
    input logic                clk,
    input logic                rst,
    sobel_frame_ctrl_if.master bus
);

    localparam int               NPIX      = IMG_W * IMG_H;
    localparam int               CNT_W     = $clog2(NPIX);
    localparam int               OUT_N     = out_cnt(IMG_W, IMG_H);
    localparam int               DR_W      = $clog2(DRAIN_MAX + 1);
    localparam logic [CNT_W-1:0] OUT_LAST  = CNT_W'(OUT_N);
    localparam logic [CNT_W-1:0] OUT_PRE   = CNT_W'(OUT_N - 1);
    localparam logic [DR_W-1:0]  DRAIN_END = DR_W'(DRAIN_MAX - 1);

    ctrl_state_t      state;
    ctrl_state_t      next_state;
    logic [CNT_W-1:0] wr_cnt;
    logic [DR_W-1:0]  drain_cnt;
    logic             timeout_q;
    logic             timeout_hit;
    logic             active;
    logic             frame_start;
    logic             write_ok;
    logic             writes_complete;
    logic             last_read;

    assign active      = (state == FEED) || (state == DRAIN);
    assign frame_start = (state == IDLE) && bus.start && !bus.abort;
    assign write_ok    = active && bus.edge_valid && (wr_cnt != OUT_LAST);

    // Completion is recognised on the final write itself so DONE follows immediately.
    assign writes_complete = (wr_cnt == OUT_LAST) || (write_ok && (wr_cnt == OUT_PRE));

    sobel_frame_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .clear      (frame_start),
        .enable     (state == FEED),
        .filt_ready (bus.filt_ready),
        .rd_data    (bus.rd_data),
        .rd_en      (bus.rd_en),
        .rd_addr    (bus.rd_addr),
        .last_read  (last_read),
        .pix_valid  (bus.pix_valid),
        .pixel_data (bus.pixel_data)
    );

    always_comb begin
        next_state  = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    next_state = FEED;
                end
            end
            FEED: begin
                if (bus.abort) begin
                    next_state = IDLE;
                end else if (last_read) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.abort) begin
                    next_state = IDLE;
                end else if (writes_complete) begin
                    next_state = DONE;
                end else if (drain_cnt == DRAIN_END) begin
                    next_state  = DONE;
                    timeout_hit = 1'b1;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            wr_cnt    <= '0;
            drain_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            state <= next_state;
            if (frame_start) begin
                wr_cnt    <= '0;
                drain_cnt <= '0;
                timeout_q <= 1'b0;
            end else begin
                if (write_ok) begin
                    wr_cnt <= wr_cnt + CNT_W'(1);
                end
                if (state == DRAIN) begin
                    drain_cnt <= drain_cnt + DR_W'(1);
                end
                if (timeout_hit) begin
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    assign bus.wr_en   = write_ok;
    assign bus.wr_addr = ADDR_W'(wr_cnt);
    assign bus.wr_data = write_ok ? bus.edge_pixel : '0;
    assign bus.busy    = active;
    assign bus.done    = (state == DONE);
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl on a 4x4 image with an 8-cycle drain limit.
// Frame cycle 0 is the start cycle; expected cycles below are counted from it.
module tb_sobel_frame_ctrl;
    import sobel_pkg::*;

    logic clk;
    logic rst;
    sobel_frame_ctrl_if bus();

    sobel_frame_ctrl #(
        .IMG_W     (4),
        .IMG_H     (4),
        .DRAIN_MAX (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [13:0] rd_log[$];
    int          rd_cyc_log[$];
    logic [7:0]  pix_log[$];
    logic [13:0] wr_addr_log[$];
    logic [7:0]  wr_data_log[$];
    logic [13:0] stall_addr_log[$];
    int          done_cnt;
    int          done_cyc;
    logic        done_to;
    logic        busy_at[64];
    logic        rd_en_at[64];
    logic        wr_en_at[64];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] pix_of(input logic [13:0] a);
        return 8'(a * 14'd13 + 14'd5);
    endfunction

    // Source frame buffer with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= pix_of(bus.rd_addr);
    end

    task automatic clear_logs();
        rd_log.delete();
        rd_cyc_log.delete();
        pix_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        stall_addr_log.delete();
        done_cnt = 0;
        done_cyc = -1;
        done_to  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            busy_at[i]  = 1'b0;
            rd_en_at[i] = 1'b0;
            wr_en_at[i] = 1'b0;
        end
    endtask

    task automatic step(input int c);
        #1;
        if (c >= 0 && c < 64) begin
            busy_at[c]  = bus.busy;
            rd_en_at[c] = bus.rd_en;
            wr_en_at[c] = bus.wr_en;
        end
        if (bus.rd_en) begin
            rd_log.push_back(bus.rd_addr);
            rd_cyc_log.push_back(c);
        end
        if (bus.pix_valid) pix_log.push_back(bus.pixel_data);
        if (bus.wr_en) begin
            wr_addr_log.push_back(bus.wr_addr);
            wr_data_log.push_back(bus.wr_data);
        end
        if (!bus.filt_ready && bus.busy) stall_addr_log.push_back(bus.rd_addr);
        if (bus.done) begin
            done_cnt++;
            done_cyc = c;
            done_to  = bus.timeout;
        end
        @(negedge clk);
    endtask

    task automatic run_frame(input int n_edges, input int edge_first, input int edge_step,
                             input int stall_lo, input int stall_hi, input int abort_at,
                             input int extra_start_at, input int stop_at, input int max_cyc);
        int k = 0;
        clear_logs();
        for (int c = 0; c < max_cyc; c++) begin
            bus.start      = (c == 0) || (c == extra_start_at);
            bus.abort      = (c == abort_at);
            bus.filt_ready = !((c - 1) >= stall_lo && (c - 1) <= stall_hi);
            if (k < n_edges && c == edge_first + k * edge_step) begin
                bus.edge_valid = 1'b1;
                bus.edge_pixel = 8'hA0 + 8'(k);
                k++;
            end else begin
                bus.edge_valid = 1'b0;
                bus.edge_pixel = 8'h00;
            end
            step(c);
            if (c == stop_at || (done_cnt > 0 && c > done_cyc)) break;
        end
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.edge_valid = 1'b0;
        bus.edge_pixel = 8'h00;
        bus.filt_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.timeout, bus.rd_en, bus.pix_valid, bus.wr_en} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got %b expected 000000",
                     {bus.busy, bus.done, bus.timeout, bus.rd_en, bus.pix_valid, bus.wr_en});
        end
        n_checks++;
        if ({bus.rd_addr, bus.wr_addr, bus.pixel_data, bus.wr_data} !== 44'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got rd_addr=%0d wr_addr=%0d pix=%0d wr_data=%0d expected all 0",
                     bus.rd_addr, bus.wr_addr, bus.pixel_data, bus.wr_data);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_start_abort_idle();
        clear_logs();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step(0);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        step(1);
        step(2);
        n_checks++;
        if ({busy_at[1], busy_at[2]} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL start_abort_busy: got %b expected 00", {busy_at[1], busy_at[2]});
        end
        n_checks++;
        if (rd_log.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL start_abort_reads: got %0d expected 0", rd_log.size());
        end
    endtask

    task automatic test_nominal();
        run_frame(4, 6, 4, 1, 0, -1, -1, -1, 40);
        n_checks++;
        if (rd_log.size() != 16) begin
            n_fail++;
            $display("[TB] FAIL nom_rd_count: got %0d expected 16", rd_log.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if (rd_log[i] !== 14'(i)) begin
                    n_fail++;
                    $display("[TB] FAIL nom_rd_addr[%0d]: got %0d expected %0d", i, rd_log[i], i);
                end
            end
            n_checks++;
            if (rd_cyc_log[0] != 1 || rd_cyc_log[15] != 16) begin
                n_fail++;
                $display("[TB] FAIL nom_rd_cycles: got %0d..%0d expected 1..16", rd_cyc_log[0], rd_cyc_log[15]);
            end
        end
        n_checks++;
        if (pix_log.size() != 16) begin
            n_fail++;
            $display("[TB] FAIL nom_pix_count: got %0d expected 16", pix_log.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if (pix_log[i] !== pix_of(14'(i))) begin
                    n_fail++;
                    $display("[TB] FAIL nom_pixel[%0d]: got %0h expected %0h", i, pix_log[i], pix_of(14'(i)));
                end
            end
        end
        n_checks++;
        if (wr_addr_log.size() != 4) begin
            n_fail++;
            $display("[TB] FAIL nom_wr_count: got %0d expected 4", wr_addr_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (wr_addr_log[i] !== 14'(i) || wr_data_log[i] !== 8'hA0 + 8'(i)) begin
                    n_fail++;
                    $display("[TB] FAIL nom_write[%0d]: got addr=%0d data=%0h expected addr=%0d data=%0h",
                             i, wr_addr_log[i], wr_data_log[i], i, 8'hA0 + 8'(i));
                end
            end
        end
        n_checks++;
        if (done_cnt != 1 || done_cyc != 19 || done_to !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL nom_done: got count=%0d cycle=%0d timeout=%b expected count=1 cycle=19 timeout=0",
                     done_cnt, done_cyc, done_to);
        end
    endtask

    task automatic test_backpressure();
        run_frame(4, 6, 4, 3, 5, -1, -1, -1, 45);
        n_checks++;
        if (stall_addr_log.size() != 3) begin
            n_fail++;
            $display("[TB] FAIL bp_stall_cycles: got %0d expected 3", stall_addr_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (stall_addr_log[i] !== 14'd3) begin
                    n_fail++;
                    $display("[TB] FAIL bp_hold_addr[%0d]: got %0d expected 3", i, stall_addr_log[i]);
                end
            end
        end
        n_checks++;
        if (rd_log.size() != 16 || pix_log.size() != 16) begin
            n_fail++;
            $display("[TB] FAIL bp_counts: got reads=%0d pixels=%0d expected 16/16", rd_log.size(), pix_log.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if (rd_log[i] !== 14'(i) || pix_log[i] !== pix_of(14'(i))) begin
                    n_fail++;
                    $display("[TB] FAIL bp_stream[%0d]: got addr=%0d pix=%0h expected addr=%0d pix=%0h",
                             i, rd_log[i], pix_log[i], i, pix_of(14'(i)));
                end
            end
            n_checks++;
            if (rd_cyc_log[3] != 7) begin
                n_fail++;
                $display("[TB] FAIL bp_resume_cycle: got %0d expected 7", rd_cyc_log[3]);
            end
        end
        n_checks++;
        if (done_cnt != 1 || done_cyc != 21 || wr_addr_log.size() != 4) begin
            n_fail++;
            $display("[TB] FAIL bp_done: got count=%0d cycle=%0d writes=%0d expected 1/21/4",
                     done_cnt, done_cyc, wr_addr_log.size());
        end
    endtask

    task automatic test_timeout();
        run_frame(2, 6, 4, 1, 0, -1, -1, -1, 45);
        n_checks++;
        if (done_cnt != 1 || done_cyc != 25 || done_to !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL to_done: got count=%0d cycle=%0d timeout=%b expected count=1 cycle=25 timeout=1",
                     done_cnt, done_cyc, done_to);
        end
        n_checks++;
        if (wr_addr_log.size() != 2) begin
            n_fail++;
            $display("[TB] FAIL to_writes: got %0d expected 2", wr_addr_log.size());
        end
        #1;
        n_checks++;
        if (bus.timeout !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL to_sticky: got timeout=%b busy=%b expected timeout=1 busy=0", bus.timeout, bus.busy);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        run_frame(5, 6, 2, 1, 0, -1, -1, -1, 40);
        n_checks++;
        if (wr_addr_log.size() != 4) begin
            n_fail++;
            $display("[TB] FAIL ovf_writes: got %0d expected 4", wr_addr_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (wr_addr_log[i] !== 14'(i) || wr_data_log[i] !== 8'hA0 + 8'(i)) begin
                    n_fail++;
                    $display("[TB] FAIL ovf_write[%0d]: got addr=%0d data=%0h expected addr=%0d data=%0h",
                             i, wr_addr_log[i], wr_data_log[i], i, 8'hA0 + 8'(i));
                end
            end
        end
        n_checks++;
        if (wr_en_at[14] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ovf_fifth_ignored: got wr_en=%b expected 0", wr_en_at[14]);
        end
        n_checks++;
        if (done_cnt != 1 || done_cyc != 18 || done_to !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ovf_done: got count=%0d cycle=%0d timeout=%b expected count=1 cycle=18 timeout=0",
                     done_cnt, done_cyc, done_to);
        end
    endtask

    task automatic test_abort();
        run_frame(4, 6, 4, 1, 0, 8, -1, -1, 20);
        n_checks++;
        if (rd_log.size() != 8 || pix_log.size() != 8) begin
            n_fail++;
            $display("[TB] FAIL abort_counts: got reads=%0d pixels=%0d expected 8/8", rd_log.size(), pix_log.size());
        end else begin
            n_checks++;
            if (rd_log[7] !== 14'd7 || pix_log[7] !== pix_of(14'd7)) begin
                n_fail++;
                $display("[TB] FAIL abort_last_read: got addr=%0d pix=%0h expected addr=7 pix=%0h",
                         rd_log[7], pix_log[7], pix_of(14'd7));
            end
        end
        n_checks++;
        if ({busy_at[8], busy_at[9], rd_en_at[9], wr_en_at[10]} !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL abort_stop: got %b expected 1000",
                     {busy_at[8], busy_at[9], rd_en_at[9], wr_en_at[10]});
        end
        n_checks++;
        if (done_cnt != 0 || wr_addr_log.size() != 1) begin
            n_fail++;
            $display("[TB] FAIL abort_no_done: got done=%0d writes=%0d expected 0/1", done_cnt, wr_addr_log.size());
        end
        run_frame(4, 6, 4, 1, 0, -1, -1, -1, 40);
        n_checks++;
        if (rd_log.size() != 16 || wr_addr_log.size() != 4) begin
            n_fail++;
            $display("[TB] FAIL restart_counts: got reads=%0d writes=%0d expected 16/4", rd_log.size(), wr_addr_log.size());
        end else begin
            n_checks++;
            if (rd_log[0] !== 14'd0 || rd_log[15] !== 14'd15 || wr_addr_log[0] !== 14'd0) begin
                n_fail++;
                $display("[TB] FAIL restart_addrs: got rd0=%0d rd15=%0d wr0=%0d expected 0/15/0",
                         rd_log[0], rd_log[15], wr_addr_log[0]);
            end
        end
        n_checks++;
        if (done_cnt != 1 || done_cyc != 19) begin
            n_fail++;
            $display("[TB] FAIL restart_done: got count=%0d cycle=%0d expected 1/19", done_cnt, done_cyc);
        end
    endtask

    task automatic test_reset_mid_frame();
        run_frame(2, 6, 4, 1, 0, -1, 5, 19, 40);
        n_checks++;
        if (rd_log.size() != 16) begin
            n_fail++;
            $display("[TB] FAIL busy_start_reads: got %0d expected 16", rd_log.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if (rd_log[i] !== 14'(i)) begin
                    n_fail++;
                    $display("[TB] FAIL busy_start_addr[%0d]: got %0d expected %0d", i, rd_log[i], i);
                end
            end
        end
        n_checks++;
        if (busy_at[19] !== 1'b1 || done_cnt != 0) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_state: got busy=%b done=%0d expected 1/0", busy_at[19], done_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.timeout, bus.rd_en, bus.pix_valid, bus.wr_en} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_flags: got %b expected 000000",
                     {bus.busy, bus.done, bus.timeout, bus.rd_en, bus.pix_valid, bus.wr_en});
        end
        n_checks++;
        if ({bus.rd_addr, bus.wr_addr, bus.pixel_data, bus.wr_data} !== 44'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_data: got rd_addr=%0d wr_addr=%0d pix=%0d wr_data=%0d expected all 0",
                     bus.rd_addr, bus.wr_addr, bus.pixel_data, bus.wr_data);
        end
        @(negedge clk);
        rst = 1'b1;
        clear_logs();
        for (int c = 0; c < 12; c++) step(c);
        n_checks++;
        if (done_cnt != 0 || busy_at[11] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL post_reset_idle: got done=%0d busy=%b expected 0/0", done_cnt, busy_at[11]);
        end
    endtask

    initial begin
        rst            = 1'b0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.filt_ready = 1'b1;
        bus.edge_valid = 1'b0;
        bus.edge_pixel = 8'h00;
        $display("[TB] sobel_frame_ctrl directed bench, 4x4 image, DRAIN_MAX=8");
        test_reset();
        test_start_abort_idle();
        test_nominal();
        test_backpressure();
        test_timeout();
        test_overflow();
        test_abort();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
